md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over a fixed cycle count.
- Raises a stall request so the hazard logic freezes the D stage, and the pipeline registers behind it, while an md-dependent instruction waits.
- Results become visible on HI/LO only after the busy window completes.

Parameters:
- MULT_CYC, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYC, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage op valid for one cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=MADDU
- A  input  32  rs operand (E stage, already forwarded)
- B  input  32  rt operand (E stage, already forwarded)
- md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd
- busy  output  1  computation in flight
- stall_md  output  1  stall request to the hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (clk edge with reset=1): busy=0, counter=0, HI=0, LO=0, pending result=0.
  - Reset wins over a simultaneous start.
  - Reset mid-operation aborts the computation; HI/LO end at 0.
- Accepting start:
  - start is accepted only when busy=0.
  - start while busy=1 is ignored. The hazard unit guarantees this never happens; the bench checks that it is ignored anyway.
- Multiply/divide ops (op 0-3), on the accepting edge:
  - A and B are latched and the product/quotient is computed into internal pending registers.
  - counter loads MULT_CYC or DIV_CYC.
  - busy goes 1 from the next cycle.
- Countdown and writeback:
  - counter decrements each cycle while busy.
  - On the edge where counter goes 1→0: HI/LO load the pending result and busy drops.
  - Result is therefore visible on HI/LO exactly N cycles after the start edge (N = MULT_CYC or DIV_CYC). busy is high for N cycles.
- MTHI/MTLO (op 4/5) with busy=0: HI or LO is written with A on the next edge. No busy cycle. The other register is unchanged.
- States:
  - IDLE→BUSY on an accepted op 0-3 (or op 6/7 when enabled).
  - BUSY→IDLE when counter reaches 0.
  - IDLE→IDLE on MTHI/MTLO.
- stall_md = md_use_D & (busy | (start & op<4)). Combinational, and covers the start cycle itself.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Divide edge cases:
  - B=0: busy runs the full DIV_CYC window and HI/LO stay unchanged.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- op 6/7 with MADD_EN undefined: treated as no-op. No busy, HI/LO unchanged.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op 6 (MADD): {HI,LO} += signed A*B, modulo 2^64.
  - op 7 (MADDU): {HI,LO} += unsigned A*B, modulo 2^64.
  - Both use the MULT_CYC busy window.
  - The accumulate uses HI/LO as sampled at the start edge.
  - stall_md also covers op 6/7 on the start cycle.
- Not defined: op 6/7 are no-ops as above, and no accumulate adder is synthesized.

Test Plan:
- reset, then MULT A=0xFFFFFFFE B=3 → busy high 5 cycles; on the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0 after.
- DIV A=0xFFFFFFF9 (-7) B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat as DIVU with A=7 B=2 → LO=3, HI=1.
- MTHI A=0x12345678, then MTLO A=0x9 → HI=0x12345678 and LO=9 one edge each; busy never asserts.
- MULTU 0x10000 × 0x10000 with md_use_D=1 held → stall_md high on the start cycle plus 5 busy cycles (6 total), then low; HI=1, LO=0.
- DIVU A=5 B=0 with prior HI=0xA, LO=0xB → busy 10 cycles; HI=0xA, LO=0xB unchanged. A second start pulsed mid-busy is ignored.
- Start DIV, assert reset at busy cycle 4 → next edge busy=0, HI=LO=0, stall_md=0. With MD_MADD_EN: HI=0, LO=5, MADD A=2 B=3 → LO=11 after 5 cycles.

Source files
------------

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, holds busy for a
// fixed window per op and requests D-stage stalls. `define MD_MADD_EN adds MADD/MADDU.
module md_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic [63:0] pend, pend_n;

  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, sq, sr, dq, dr;
  logic        is_md_op;

  // Low 64 bits of a sign-extended product are the signed product.
  assign prod = (op[0] ? {32'b0, A} : {{32{A[31]}}, A}) *
                (op[0] ? {32'b0, B} : {{32{B[31]}}, B});

  // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case.
  assign a_neg = A[31] & ~op[0];
  assign b_neg = B[31] & ~op[0];
  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;
  assign uq    = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign ur    = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign sq    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign sr    = a_neg ? (32'd0 - ur) : ur;
  assign dq    = sq;
  assign dr    = sr;

`ifdef MD_MADD_EN
  logic [63:0] macc;
  assign macc     = {hi_q, lo_q} + prod;
  assign is_md_op = (op != 3'd4) && (op != 3'd5);
`else
  assign is_md_op = ~op[2];
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    pend_n  = pend;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              pend_n  = prod;
              cnt_n   = 4'(MULT_CYC);
              state_n = BUSY;
            end
            3'd2, 3'd3: begin
              pend_n  = (B == '0) ? {hi_q, lo_q} : {dr, dq};
              cnt_n   = 4'(DIV_CYC);
              state_n = BUSY;
            end
            3'd4: hi_n = A;
            3'd5: lo_n = A;
`ifdef MD_MADD_EN
            3'd6, 3'd7: begin
              pend_n  = macc;
              cnt_n   = 4'(MULT_CYC);
              state_n = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          hi_n    = pend[63:32];
          lo_n    = pend[31:0];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pend  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      pend  <= pend_n;
    end
  end

  assign busy     = (state == BUSY);
  assign stall_md = md_use_D & (busy | (start & is_md_op));
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
